pow_engine: RTL
===============

POW_ENGINE -- requirements
Module: pow_engine

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand and result width in bits (legal range 2..32).
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on posedge clk.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port in_valid  input  1  operand request valid.
REQ-005 SHALL have port in_ready  output  1  engine can accept a request.
REQ-006 SHALL have port base  input  WIDTH  base operand.
REQ-007 SHALL have port expo  input  WIDTH  exponent operand.
REQ-008 SHALL have port is_signed  input  1  1 = both operands two's-complement signed; 0 = both unsigned.
REQ-009 SHALL have port out_valid  output  1  result valid.
REQ-010 SHALL have port out_ready  input  1  consumer accepts result.
REQ-011 SHALL have port result  output  WIDTH  base**expo truncated to WIDTH bits.
REQ-012 SHALL have port div_zero  output  1  qualifies result: zero base raised to negative exponent.

Function
REQ-013 SHALL implement FSM states IDLE, LOOP, DONE; in_ready=1 only in IDLE.
REQ-014 SHALL accept a request when in_valid && in_ready; operands and is_signed captured that cycle; later input changes ignored.
REQ-015 IDLE->LOOP on accept; LOOP runs exactly WIDTH cycles; LOOP->DONE after the WIDTH-th cycle; DONE->IDLE on out_ready.
REQ-016 out_valid SHALL be 1 only in DONE, first asserted exactly WIDTH+1 cycles after the accept edge, for all operand values.
REQ-017 Non-negative exponent (unsigned mode, or signed with expo MSB=0): square-and-multiply, LSB first; per LOOP cycle, if current exponent bit=1 then acc=acc*sq, then sq=sq*sq, exponent shifted right; acc initialised to 1, sq to base.
REQ-018 All multiplies SHALL be modulo 2^WIDTH (low WIDTH bits kept); signedness does not change the low bits of products.
REQ-019 expo=0 SHALL yield 1 for any base, including 0.
REQ-020 Negative exponent (is_signed=1, expo MSB=1), result SHALL be: base=1 -> 1; base=-1 -> 1 if expo even, all-ones if odd; base=0 -> 0 with div_zero=1; any other base -> 0.
REQ-021 Negative-exponent cases SHALL still observe the fixed WIDTH+1 latency of REQ-016.
REQ-022 div_zero SHALL be 0 for every case other than REQ-020 base=0; it is valid only while out_valid=1.
REQ-023 result and div_zero SHALL hold stable while out_valid=1 && out_ready=0 (backpressure, unbounded).
REQ-024 Accepting a new request in the same cycle the previous result is consumed is not supported: after DONE->IDLE, in_ready rises the following cycle.
REQ-025 in_valid while busy SHALL be ignored; no request is queued.

Reset
REQ-026 On rst_n low, SHALL asynchronously enter IDLE with in_ready=1, out_valid=0, result=0, div_zero=0, internal acc/sq/exponent/cycle counter=0.
REQ-027 Reset asserted mid-LOOP or in DONE SHALL discard the operation; no out_valid pulse after release.
REQ-028 First accept SHALL be possible on the first posedge clk after rst_n deasserts.

Verification (WIDTH=8, is_signed=1 unless stated)
REQ-029 Bench SHALL cover negative exponents: (1,-2)->01; (2,-2)->00; (-2,-3)->00; (-1,-3)->ff; (-1,-2)->01; all div_zero=0, out_valid exactly 9 cycles after accept.
REQ-030 Bench SHALL cover non-negative: (3,5)->f3; (-2,3)->f8; (0,0)->01; is_signed=0 (2,255)->00; (255,2)->01.
REQ-031 Bench SHALL cover zero base: (0,-1)->result 00, div_zero=1; next request (0,1)->00, div_zero=0.
REQ-032 Bench SHALL hold out_ready=0 for 20 cycles on (3,5): result stays f3, in_ready stays 0, in_valid pulses ignored; out_ready=1 -> IDLE next cycle.
REQ-033 Bench SHALL assert rst_n low in LOOP cycle 4 of (3,5): outputs at reset values immediately; no out_valid after release; new (2,7) -> 80.
REQ-034 Bench SHALL run 1000 random operand pairs in both modes against a reference model of REQ-017..REQ-020.

Source files
------------

// File: rtl/pow_engine.sv
// pow_engine: sequential power unit, result = base**expo mod 2^WIDTH,
// fixed WIDTH+1 cycle latency from accept to out_valid.
module pow_engine #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] base,
    input  logic [WIDTH-1:0] expo,
    input  logic             is_signed,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             div_zero
);
    localparam int CW = $clog2(WIDTH);
    typedef enum logic [1:0] {IDLE, LOOP, DONE} state_t;
    state_t           r_state;
    logic [WIDTH-1:0] r_acc, r_sq, r_exp, r_result;
    logic [CW-1:0]    r_cnt;
    logic             r_neg, r_dz, r_in_ready, r_out_valid, r_div_zero;
    logic             w_neg;
    logic [WIDTH-1:0] w_neg_res;
    assign w_neg = is_signed && expo[WIDTH-1];
    // Only +1 and -1 have integer reciprocals; a negative exponent is resolved at
    // accept and the accumulator is then frozen for the rest of LOOP.
    assign w_neg_res = (base == WIDTH'(1)) ? WIDTH'(1) :
                       (&base) ? (expo[0] ? '1 : WIDTH'(1)) : '0;
    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign result    = r_result;
    assign div_zero  = r_div_zero;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_acc       <= '0;
            r_sq        <= '0;
            r_exp       <= '0;
            r_cnt       <= '0;
            r_neg       <= 1'b0;
            r_dz        <= 1'b0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_result    <= '0;
            r_div_zero  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: if (in_valid) begin
                    r_state    <= LOOP;
                    r_in_ready <= 1'b0;
                    r_acc      <= w_neg ? w_neg_res : WIDTH'(1);
                    r_sq       <= base;
                    r_exp      <= expo;
                    r_cnt      <= '0;
                    r_neg      <= w_neg;
                    r_dz       <= w_neg && (base == '0);
                end
                LOOP: begin
                    if (!r_neg && r_exp[0]) r_acc <= r_acc * r_sq;
                    r_sq  <= r_sq * r_sq;
                    r_exp <= r_exp >> 1;
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == CW'(WIDTH - 1)) r_state <= DONE;
                end
                DONE: begin
                    // First DONE cycle publishes the result; later cycles wait for the consumer.
                    if (!r_out_valid) begin
                        r_out_valid <= 1'b1;
                        r_result    <= r_acc;
                        r_div_zero  <= r_dz;
                    end else if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule
